mult_sequencer: RTL

Multi-cycle shift-add sequencer that runs the MIPS `mult`/`multu` operation for the pipelined datapath. It captures two operands on `start_mult`, iterates over the multiplier bits, applies a sign correction, and commits the 2×WIDTH-bit product to HI/LO. While a multiply is in flight, it stalls any decode-stage instruction that reads HI/LO. It sits beside the execute stage and is driven by the same `start_mult`/`mult_sign` controls the control unit already produces.

---
 rtl/mult_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mult_sequencer
// Purpose  : Multi-cycle shift-add multiplier for MIPS mult/multu with HI/LO
//            commit and decode-stage HI/LO read stall.
// Options  : MULT_EARLY_TERM_EN - leave RUN once the remaining multiplier is 0
// Revision : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             hilo_read_d,
    output logic             busy,
    output logic             stall_mult,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_FIX  = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_run_exit;

    // Negating the most-negative value yields itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign w_mag_a       = (mult_sign & srca_e[WIDTH-1]) ? -srca_e : srca_e;
    assign w_mag_b       = (mult_sign & srcb_e[WIDTH-1]) ? -srcb_e : srcb_e;
    assign w_mplier_next = r_mplier >> 1;
    assign w_result      = r_neg ? -r_acc : r_acc;

`ifdef MULT_EARLY_TERM_EN
    assign w_run_exit = (r_count == c_LAST) || (w_mplier_next == '0);
`else
    assign w_run_exit = (r_count == c_LAST);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start_mult) w_next_state = c_RUN;
            c_RUN:   if (w_run_exit) w_next_state = c_FIX;
            c_FIX:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_IDLE);
        stall_mult = hilo_read_d & (r_state != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == c_FIX);
            case (r_state)
                c_IDLE: begin
                    if (start_mult) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= mult_sign & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                c_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count + CW'(1);
                end
                c_FIX: begin
                    r_hi <= w_result[2*WIDTH-1:WIDTH];
                    r_lo <= w_result[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
